maze_fetch_sched: RTL and testbench
===================================

Name: maze_fetch_sched

Overview:
- Schedules all neighbour-tile lookups into the single-port maze RAM, shared by pacman and the ghosts.
- Each frame_tick it snapshots every requester's tile coordinate, then reads the four neighbours of each requester in fixed order.
- Results are published together as a double-buffered set of 2-bit tile codes, indexed by direction code, which feed the movement logic for the next 60 Hz step.

Parameters:
- NUM_REQ, 5, number of requesters; index 0 = pacman, 1..4 = ghosts.
- MAZE_W, 28, maze width in tiles.
- MAZE_H, 31, maze height in tiles.
- RD_LAT, 1, maze RAM read latency in cycles (1..3).
- ADDR_W, 10, RAM address width; must be at least clog2(MAZE_W*MAZE_H).

Ports:
- clk25  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse in the clk25 domain marking each 60 Hz step.
- req_valid  in  NUM_REQ  requester active.
- req_xtile  in  NUM_REQ x 7  requester tile column.
- req_ytile  in  NUM_REQ x 7  requester tile row.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM address; address = y*MAZE_W + x.
- mem_rd_data  in  2  tile code returned RD_LAT cycles after mem_rd_en.
- tile_info  out  NUM_REQ x 4 x 2  neighbour codes, indexed by direction code.
- info_valid  out  1  one-cycle pulse when tile_info updates.
- busy  out  1  high from frame_tick acceptance until the cycle of info_valid.
- overrun  out  1  sticky flag: a frame_tick arrived while busy.

Behaviour:
- Encodings:
  - Directions: RIGHT=00, UP=01, DOWN=10, LEFT=11.
  - Tiles: WALL=00, WKNP=01, WKRP=10, WKGH=11.
- Reset: tile_info all WALL; info_valid, busy, mem_rd_en and overrun all 0; FSM in IDLE. Reset mid-sweep aborts the sweep immediately; partial results are discarded.
- FSM states:
  - IDLE: wait for frame_tick.
  - ISSUE: one slot per cycle.
  - DRAIN: wait RD_LAT cycles for the last read data.
  - PUBLISH: copy the shadow buffer to tile_info.
  - Then return to IDLE.
- Snapshot: on frame_tick in IDLE (cycle 0), latch req_valid, req_xtile and req_ytile. Later input changes are ignored until the next sweep.
- Slot order: requester 0..NUM_REQ-1; within each requester, direction order RIGHT, UP, LEFT, DOWN. Always exactly 4*NUM_REQ slots, in cycles 1..4*NUM_REQ, so latency is deterministic.
- Slot rules:
  - Requester invalid: no read; its tile_info entries hold their previous value.
  - Centre out of range (x>=MAZE_W or y>=MAZE_H): no read; all four codes = WALL.
  - Horizontal wrap (tunnel): x=0 LEFT uses x=MAZE_W-1; x=MAZE_W-1 RIGHT uses x=0.
  - Vertical edge: y=0 UP and y=MAZE_H-1 DOWN give WALL with no read.
- Return path: each read carries a (req, dir) tag through an RD_LAT-deep shift register; returned data is written into the shadow buffer at that tag.
- info_valid: asserted at cycle 4*NUM_REQ+RD_LAT+1, together with the tile_info update.
- busy: drops in the same cycle as info_valid.
- frame_tick during busy: ignored and sets overrun; overrun clears only on reset.
- frame_tick coincident with info_valid: counts as busy (ignored, sets overrun).

Optional Feature:
- Macro: MAZE_PELLET_CLEAR_EN.
- When defined:
  - Adds ports mem_wr_en (out, 1), mem_wr_data (out, 2) and pellet_eaten (out, 1).
  - Extra slot at cycle 4*NUM_REQ+1 reads requester 0's centre tile, if valid and in range.
  - If the returned code is WKRP, the next cycle writes WKNP to the same address; no read is issued in that cycle.
  - info_valid moves to cycle 4*NUM_REQ+RD_LAT+3, with pellet_eaten pulsing in the same cycle.
- When undefined: the extra ports are absent and timing is as in Behaviour.

Decomposition:
- maze_pkg holds:
  - direction localparams and tile-code localparams;
  - MAZE_W and MAZE_H defaults;
  - an FSM state enum typedef.
- Sub-module maze_neighbor_addr (combinational): inputs centre x/y and direction; outputs address and skip flag. It encodes the wrap and bounds rules.

Test Plan:
- Requester 0 at (13,23), others invalid, frame_tick → reads to 658, 629, 656, 685 in cycles 1-4; info_valid at cycle 22 (N=5, RD_LAT=1) with tile_info[0] matching the RAM model; tile_info[1..4] unchanged.
- Requester 0 at (0,14) → LEFT read address 419; requester 0 at (27,14) → RIGHT read address 392.
- Requester at (1,0) → no UP read, tile_info UP = WALL; requester at (5,40) → no reads, all four WALL.
- frame_tick at cycles 0 and 10 → one sweep only, overrun=1, info_valid once at cycle 22.
- reset_n low at cycle 8 → immediately all outputs WALL/0, no info_valid; next frame_tick sweeps normally.
- With MAZE_PELLET_CLEAR_EN, centre tile WKRP at (13,23) → read of address 657, write of WKNP at cycle 23, pellet_eaten and info_valid at cycle 24. With centre WKNP → no write, pellet_eaten=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared encodings and FSM state type for the maze neighbour-fetch scheduler.
package maze_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [1:0] TILE_WALL = 2'b00;
    localparam logic [1:0] TILE_WKNP = 2'b01;
    localparam logic [1:0] TILE_WKRP = 2'b10;
    localparam logic [1:0] TILE_WKGH = 2'b11;

    localparam int MAZE_W_DEF = 28;
    localparam int MAZE_H_DEF = 31;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_ISSUE,
        FSM_DRAIN,
        FSM_PUBLISH
    } fsm_state_e;

    // Slot position within a requester maps to RIGHT, UP, LEFT, DOWN.
    function automatic logic [1:0] slot_dir(input logic [1:0] pos);
        return {pos[1], pos[1] ^ pos[0]};
    endfunction

endpackage

// File: rtl/maze_neighbor_addr.sv
// Neighbour tile address for one (centre, direction) pair, with tunnel wrap
// and top/bottom edge handling; o_skip means "no read, code is WALL".
module maze_neighbor_addr
    import maze_pkg::*;
#(
    parameter int MAZE_W = MAZE_W_DEF,
    parameter int MAZE_H = MAZE_H_DEF,
    parameter int ADDR_W = 10
) (
    input  logic [6:0]        i_x,
    input  logic [6:0]        i_y,
    input  logic [1:0]        i_dir,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_skip
);

    localparam logic [6:0] W_LAST = 7'(MAZE_W - 1);
    localparam logic [6:0] H_LAST = 7'(MAZE_H - 1);

    logic [6:0] w_nx;
    logic [6:0] w_ny;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_nx   = i_x;
        w_ny   = i_y;
        o_skip = (i_x > W_LAST) || (i_y > H_LAST);
        case (i_dir)
            DIR_RIGHT: w_nx = (i_x == W_LAST) ? 7'd0 : i_x + 7'd1;
            DIR_LEFT:  w_nx = (i_x == 7'd0) ? W_LAST : i_x - 7'd1;
            DIR_UP: begin
                if (i_y == 7'd0) o_skip = 1'b1;
                else             w_ny = i_y - 7'd1;
            end
            DIR_DOWN: begin
                if (i_y == H_LAST) o_skip = 1'b1;
                else               w_ny = i_y + 7'd1;
            end
            default: ;
        endcase
    end

    assign o_addr = ADDR_W'(w_ny) * ADDR_W'(MAZE_W) + ADDR_W'(w_nx);

endmodule

// File: rtl/maze_fetch_sched.sv
// Per-frame neighbour-tile fetch scheduler for the shared single-port maze RAM.
// Optional pellet clearing of pacman's centre tile under MAZE_PELLET_CLEAR_EN.
module maze_fetch_sched
    import maze_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int MAZE_W  = MAZE_W_DEF,
    parameter int MAZE_H  = MAZE_H_DEF,
    parameter int RD_LAT  = 1,
    parameter int ADDR_W  = 10
) (
    input  logic                          clk25,
    input  logic                          reset_n,
    input  logic                          frame_tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][6:0]       req_xtile,
    input  logic [NUM_REQ-1:0][6:0]       req_ytile,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [1:0]                    mem_rd_data,
`ifdef MAZE_PELLET_CLEAR_EN
    output logic                          mem_wr_en,
    output logic [1:0]                    mem_wr_data,
    output logic                          pellet_eaten,
`endif
    output logic [NUM_REQ-1:0][3:0][1:0]  tile_info,
    output logic                          info_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NSLOT = 4 * NUM_REQ;
`ifdef MAZE_PELLET_CLEAR_EN
    localparam int LAST_ISSUE = NSLOT + 1;
    localparam int PUB_CYC    = NSLOT + RD_LAT + 3;
`else
    localparam int LAST_ISSUE = NSLOT;
    localparam int PUB_CYC    = NSLOT + RD_LAT + 1;
`endif
    localparam logic [7:0] C_NSLOT  = 8'(NSLOT);
    localparam logic [7:0] C_LAST   = 8'(LAST_ISSUE);
    localparam logic [7:0] C_PREPUB = 8'(PUB_CYC - 1);

    localparam logic [1:0] S_IDLE    = FSM_IDLE;
    localparam logic [1:0] S_ISSUE   = FSM_ISSUE;
    localparam logic [1:0] S_DRAIN   = FSM_DRAIN;
    localparam logic [1:0] S_PUBLISH = FSM_PUBLISH;

    typedef struct packed {
        logic             vld;
        logic             pel;
        logic [REQ_W-1:0] req;
        logic [1:0]       dir;
    } tag_t;

    logic [1:0]                   r_state;
    logic [7:0]                   r_cnt;
    logic [NUM_REQ-1:0]           r_v;
    logic [NUM_REQ-1:0][6:0]      r_x;
    logic [NUM_REQ-1:0][6:0]      r_y;
    logic [NUM_REQ-1:0][3:0][1:0] r_shadow;
    logic [NUM_REQ-1:0][3:0][1:0] r_tile_info;
    logic                         r_overrun;
    tag_t                         r_tag [RD_LAT];

    logic [7:0]                   w_slot;
    logic                         w_nb_slot;
    logic [REQ_W-1:0]             w_req;
    logic [1:0]                   w_dir;
    logic [ADDR_W-1:0]            w_nb_addr;
    logic                         w_skip;
    logic                         w_rd_nb;
    logic                         w_wall_nb;
    logic                         w_rd_pel;
    tag_t                         w_new_tag;
    tag_t                         w_ret;
    logic [NUM_REQ-1:0][3:0][1:0] w_shadow_nxt;

    assign w_slot    = r_cnt - 8'd1;
    assign w_nb_slot = (r_state == S_ISSUE) && (r_cnt <= C_NSLOT);
    assign w_req     = w_nb_slot ? REQ_W'(w_slot[7:2]) : '0;
    assign w_dir     = slot_dir(w_slot[1:0]);

    maze_neighbor_addr #(
        .MAZE_W (MAZE_W),
        .MAZE_H (MAZE_H),
        .ADDR_W (ADDR_W)
    ) u_nb (
        .i_x    (r_x[w_req]),
        .i_y    (r_y[w_req]),
        .i_dir  (w_dir),
        .o_addr (w_nb_addr),
        .o_skip (w_skip)
    );

    assign w_rd_nb   = w_nb_slot && r_v[w_req] && !w_skip;
    assign w_wall_nb = w_nb_slot && r_v[w_req] && w_skip;
    assign mem_rd_en = w_rd_nb || w_rd_pel;
    assign w_ret     = r_tag[RD_LAT-1];

`ifdef MAZE_PELLET_CLEAR_EN
    localparam logic [6:0] W_LAST = 7'(MAZE_W - 1);
    localparam logic [6:0] H_LAST = 7'(MAZE_H - 1);

    logic              r_pel_wr;
    logic              r_pel_hit;
    logic              w_c0_in;
    logic              w_pel_ret_wkrp;
    logic [ADDR_W-1:0] w_c0_addr;

    assign w_c0_in        = r_v[0] && (r_x[0] <= W_LAST) && (r_y[0] <= H_LAST);
    assign w_c0_addr      = ADDR_W'(r_y[0]) * ADDR_W'(MAZE_W) + ADDR_W'(r_x[0]);
    assign w_rd_pel       = (r_state == S_ISSUE) && (r_cnt == C_LAST) && w_c0_in;
    assign w_pel_ret_wkrp = w_ret.vld && w_ret.pel && (mem_rd_data == TILE_WKRP);

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_pel_wr  <= 1'b0;
            r_pel_hit <= 1'b0;
        end else begin
            r_pel_wr <= w_pel_ret_wkrp;
            if (r_state == S_IDLE && frame_tick) r_pel_hit <= 1'b0;
            else if (w_pel_ret_wkrp)             r_pel_hit <= 1'b1;
        end
    end

    // The write cycle re-uses the centre address; no read shares it.
    assign mem_addr     = (w_rd_pel || r_pel_wr) ? w_c0_addr : w_nb_addr;
    assign mem_wr_en    = r_pel_wr;
    assign mem_wr_data  = TILE_WKNP;
    assign pellet_eaten = info_valid && r_pel_hit;
`else
    assign w_rd_pel = 1'b0;
    assign mem_addr = w_nb_addr;
`endif

    always_comb begin
        w_new_tag.vld = mem_rd_en;
        w_new_tag.pel = w_rd_pel;
        w_new_tag.req = w_req;
        w_new_tag.dir = w_dir;
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wall_nb)
            w_shadow_nxt[w_req][w_dir] = TILE_WALL;
        if (w_ret.vld && !w_ret.pel)
            w_shadow_nxt[w_ret.req][w_ret.dir] = mem_rd_data;
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_v       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (frame_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_state <= S_ISSUE;
                        r_cnt   <= 8'd1;
                        r_v     <= req_valid;
                        r_x     <= req_xtile;
                        r_y     <= req_ytile;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == C_LAST) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == C_PREPUB) r_state <= S_PUBLISH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the shadow buffer and tag pipe are reset too, so an aborted sweep leaves no stale tags.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow    <= '0;
            r_tile_info <= '0;
            for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
        end else begin
            // Seeding from the published set keeps invalid requesters' entries unchanged.
            if (r_state == S_IDLE && frame_tick) r_shadow <= r_tile_info;
            else                                 r_shadow <= w_shadow_nxt;
            if (r_state == S_DRAIN && r_cnt == C_PREPUB) r_tile_info <= w_shadow_nxt;
            r_tag[0] <= w_new_tag;
            for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign tile_info  = r_tile_info;
    assign info_valid = (r_state == S_PUBLISH);
    assign busy       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_maze_fetch_sched.sv
// Directed bench for maze_fetch_sched; also covers MAZE_PELLET_CLEAR_EN builds.
module tb_maze_fetch_sched;

    localparam int NUM_REQ = 5;
    localparam int RD_LAT  = 1;
    localparam int NSLOT   = 4 * NUM_REQ;
`ifdef MAZE_PELLET_CLEAR_EN
    localparam int PUB_CYC = NSLOT + RD_LAT + 3;
    localparam int WR_CYC  = NSLOT + RD_LAT + 2;
`else
    localparam int PUB_CYC = NSLOT + RD_LAT + 1;
`endif

    typedef struct {
        int r;
        int x;
        int y;
        int ea_r;
        int ea_u;
        int ea_l;
        int ea_d;
        int tick2;
        bit scr;
        int ccode;
    } vec_t;

    logic                          clk25 = 1'b0;
    logic                          reset_n;
    logic                          frame_tick;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][6:0]       req_xtile;
    logic [NUM_REQ-1:0][6:0]       req_ytile;
    logic                          mem_rd_en;
    logic [9:0]                    mem_addr;
    logic [1:0]                    mem_rd_data;
    logic [NUM_REQ-1:0][3:0][1:0]  tile_info;
    logic                          info_valid;
    logic                          busy;
    logic                          overrun;
`ifdef MAZE_PELLET_CLEAR_EN
    logic                          mem_wr_en;
    logic [1:0]                    mem_wr_data;
    logic                          pellet_eaten;
`endif

    logic [1:0] mem [0:1023];
    logic [1:0] rd_q = 2'b00;
    logic [NUM_REQ-1:0][3:0][1:0] exp_info;
    int total = 0;
    int bad   = 0;
    vec_t tbl [10];

    always #5 clk25 = ~clk25;

    maze_fetch_sched #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk25        (clk25),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .req_valid    (req_valid),
        .req_xtile    (req_xtile),
        .req_ytile    (req_ytile),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
`ifdef MAZE_PELLET_CLEAR_EN
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .pellet_eaten (pellet_eaten),
`endif
        .tile_info    (tile_info),
        .info_valid   (info_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Single-port RAM model with one cycle of read latency.
    always @(posedge clk25) begin
        if (mem_rd_en) rd_q <= mem[mem_addr];
`ifdef MAZE_PELLET_CLEAR_EN
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
`endif
    end
    assign mem_rd_data = rd_q;

    function automatic logic [1:0] exp_tile(input int a);
        return 2'((a % 3) + 1);
    endfunction

    task automatic init_mem();
        for (int a = 0; a < 1024; a++) mem[a] = exp_tile(a);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk25);
        @(negedge clk25);
        reset_n = 1'b1;
        exp_info = '0;
        @(negedge clk25);
    endtask

    // Entered at a falling edge; the tick is raised for cycle 0.
    task automatic do_sweep(input vec_t v);
        int ea [4];
        logic [1:0] dcode [4];
        int base, iv_cyc, stray, cen, k;
        logic exp_pel_rd, exp_wr;
        ea    = '{v.ea_r, v.ea_u, v.ea_l, v.ea_d};
        dcode = '{2'd0, 2'd1, 2'd3, 2'd2};
        init_mem();
        cen = v.y * 28 + v.x;
        exp_pel_rd = (v.r == 0) && (v.x < 28) && (v.y < 31);
        if (exp_pel_rd && v.ccode >= 0) mem[cen] = 2'(v.ccode);
        exp_wr = 1'b0;
        if (exp_pel_rd) exp_wr = (mem[cen] == 2'd2);
        base = 1 + 4 * v.r;
        req_valid = '0;
        req_xtile = '0;
        req_ytile = '0;
        req_valid[v.r] = 1'b1;
        req_xtile[v.r] = 7'(v.x);
        req_ytile[v.r] = 7'(v.y);
        frame_tick = 1'b1;
        @(negedge clk25);
        iv_cyc = -1;
        stray  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c >= base && c < base + 4) begin
                k = c - base;
                if (ea[k] < 0) begin
                    check($sformatf("no_read r%0d c%0d", v.r, c), 64'(mem_rd_en), 64'(0));
                end else begin
                    check($sformatf("rd_en r%0d c%0d", v.r, c), 64'(mem_rd_en), 64'(1));
                    check($sformatf("rd_addr r%0d c%0d", v.r, c), 64'(mem_addr), 64'(ea[k]));
                end
            end
`ifdef MAZE_PELLET_CLEAR_EN
            else if (c == NSLOT + 1 && exp_pel_rd) begin
                check("pel_rd_en", 64'(mem_rd_en), 64'(1));
                check("pel_rd_addr", 64'(mem_addr), 64'(cen));
            end
`endif
            else if (mem_rd_en) stray++;
`ifdef MAZE_PELLET_CLEAR_EN
            if (c == WR_CYC) begin
                check("wr_en", 64'(mem_wr_en), 64'(exp_wr));
                if (exp_wr) begin
                    check("wr_addr", 64'(mem_addr), 64'(cen));
                    check("wr_data", 64'(mem_wr_data), 64'(1));
                end
            end else if (mem_wr_en) stray++;
            if (info_valid && iv_cyc < 0)
                check("pellet_eaten", 64'(pellet_eaten), 64'(exp_wr));
`endif
            if (c == 1) check("busy_start", 64'(busy), 64'(1));
            if (info_valid) begin
                if (iv_cyc < 0) iv_cyc = c;
                else            stray++;
            end
            frame_tick = (c == v.tick2);
            if (v.scr && c == 2) begin
                req_valid = '1;
                req_xtile = {NUM_REQ{7'd3}};
                req_ytile = {NUM_REQ{7'd3}};
            end
            @(negedge clk25);
        end
        frame_tick = 1'b0;
        check($sformatf("iv_cycle r%0d", v.r), 64'(iv_cyc), 64'(PUB_CYC));
        check($sformatf("stray r%0d", v.r), 64'(stray), 64'(0));
        check("busy_end", 64'(busy), 64'(0));
        for (int j = 0; j < 4; j++)
            exp_info[v.r][dcode[j]] = (ea[j] < 0) ? 2'b00 : exp_tile(ea[j]);
        for (int i = 0; i < NUM_REQ; i++)
            check($sformatf("tile_info[%0d]", i), 64'(tile_info[i]), 64'(exp_info[i]));
    endtask

    initial begin
        vec_t v;
        int cnt;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        req_valid  = '0;
        req_xtile  = '0;
        req_ytile  = '0;
        exp_info   = '0;
        init_mem();

        tbl[0] = '{0, 13, 23, 658, 629, 656, 685, -1, 1'b0, -1};
        tbl[1] = '{0,  0, 14, 393, 364, 419, 420, -1, 1'b0, -1};
        tbl[2] = '{0, 27, 14, 392, 391, 418, 447, -1, 1'b0, -1};
        tbl[3] = '{3,  1,  0,   2,  -1,   0,  29, -1, 1'b0, -1};
        tbl[4] = '{1,  5, 40,  -1,  -1,  -1,  -1, -1, 1'b0, -1};
        tbl[5] = '{4, 10, 30, 851, 822, 849,  -1, -1, 1'b0, -1};
        tbl[6] = '{2, 28,  5,  -1,  -1,  -1,  -1, -1, 1'b0, -1};
        tbl[7] = '{0, 13, 23, 658, 629, 656, 685, -1, 1'b1, -1};
        tbl[8] = '{0, 13, 23, 658, 629, 656, 685, -1, 1'b0,  2};
        tbl[9] = '{0, 13, 23, 658, 629, 656, 685, -1, 1'b0,  1};

        repeat (2) @(negedge clk25);
        check("rst_tile_info", 64'(tile_info), 64'(0));
        check("rst_info_valid", 64'(info_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rd_en", 64'(mem_rd_en), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        reset_n = 1'b1;
        @(negedge clk25);

        for (int i = 0; i < 10; i++) do_sweep(tbl[i]);
        check("no_overrun", 64'(overrun), 64'(0));

        // Second tick while busy: ignored, flags overrun.
        v = tbl[0];
        v.tick2 = 10;
        do_sweep(v);
        check("overrun_busy", 64'(overrun), 64'(1));
        do_reset();
        check("overrun_cleared", 64'(overrun), 64'(0));
        check("reset_tile_info", 64'(tile_info), 64'(0));

        // Tick coincident with info_valid: also ignored.
        v = tbl[0];
        v.tick2 = PUB_CYC;
        do_sweep(v);
        check("overrun_publish", 64'(overrun), 64'(1));

        // Reset asserted in cycle 8 of a sweep.
        init_mem();
        req_valid = 5'b00001;
        req_xtile = '0;
        req_ytile = '0;
        req_xtile[0] = 7'd13;
        req_ytile[0] = 7'd23;
        frame_tick = 1'b1;
        @(negedge clk25);
        frame_tick = 1'b0;
        repeat (7) @(negedge clk25);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tile_info", 64'(tile_info), 64'(0));
        check("mid_rst_info_valid", 64'(info_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_rd_en", 64'(mem_rd_en), 64'(0));
        check("mid_rst_overrun", 64'(overrun), 64'(0));
        exp_info = '0;
        @(negedge clk25);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (info_valid || mem_rd_en || busy) cnt++;
            @(negedge clk25);
        end
        check("mid_rst_quiet", 64'(cnt), 64'(0));
        do_sweep(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
